// File: rtl/scan_decoder_pkg.sv
// Shared definitions for the scan decoder: mode encodings, legal parameter
// bounds and the one-hot helpers used by the interface and the datapath.
package scan_decoder_pkg;

   typedef enum logic {
      MODE_DIRECT = 1'b0,
      MODE_SCAN   = 1'b1
   } mode_e;

   localparam int SEL_W_MIN = 1;
   localparam int SEL_W_MAX = 5;

   function automatic int onehot_width(input int sel_w);
      return 32'sd1 << sel_w;
   endfunction

   function automatic logic [31:0] onehot32(input logic [4:0] i);
      return 32'd1 << i;
   endfunction

endpackage

// File: rtl/scan_decoder_if.sv
// Control/status bundle between a scan decoder and whatever drives it.
interface scan_decoder_if
   import scan_decoder_pkg::*;
#(
   parameter int SEL_W = 2
) ();
   localparam int N = onehot_width(SEL_W);

   logic             en_n;
   logic             mode;
   logic             load;
   logic [SEL_W-1:0] sel;
   logic [N-1:0]     y;
   logic [SEL_W-1:0] idx;
   logic             wrap;

   modport master (
      output en_n, mode, load, sel,
      input  y, idx, wrap
   );

   modport slave (
      input  en_n, mode, load, sel,
      output y, idx, wrap
   );
endinterface

// File: rtl/scan_decoder_dwell_counter.sv
// Dwell counter: counts enabled cycles 0..DWELL-1 and flags the last one.
// tc is combinational so the caller can advance in the same cycle.
module dwell_counter #(
   parameter int DWELL = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic tc
);
   localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             last_s;

   assign last_s = (cnt_q == CNT_LAST);
   assign tc     = en & last_s;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = {CNT_W{1'b0}};
      end else if (en) begin
         cnt_d = last_s ? {CNT_W{1'b0}} : cnt_q + CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= {CNT_W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/scan_decoder.sv
// Registered one-hot decoder with direct load and auto-scan modes.
// Priority at each edge: reset, disable, load, scan advance.
module scan_decoder
   import scan_decoder_pkg::*;
#(
   parameter int SEL_W      = 2,
   parameter int DWELL      = 4,
   parameter int ACTIVE_LOW = 0
) (
   input logic           clk,
   input logic           reset,
   scan_decoder_if.slave bus
);
   localparam int   N   = onehot_width(SEL_W);
   localparam logic INV = (ACTIVE_LOW != 0);

   generate
      if (SEL_W < SEL_W_MIN || SEL_W > SEL_W_MAX) begin : g_bad_sel_w
         $error("scan_decoder: SEL_W must be in 1..5");
      end
      if (DWELL < 1) begin : g_bad_dwell
         $error("scan_decoder: DWELL must be >= 1");
      end
      if (ACTIVE_LOW != 0 && ACTIVE_LOW != 1) begin : g_bad_active_low
         $error("scan_decoder: ACTIVE_LOW must be 0 or 1");
      end
   endgenerate

   logic             enabled_s;
   logic             scan_s;
   logic             load_s;
   logic             clr_s;
   logic             adv_en_s;
   logic             tc_s;
   logic [SEL_W-1:0] idx_q, idx_d;
   logic [N-1:0]     y_q, y_d;
   logic             wrap_q, wrap_d;

   assign enabled_s = ~bus.en_n;
   assign scan_s    = (mode_e'(bus.mode) == MODE_SCAN);
   assign load_s    = enabled_s & bus.load;
   // Direct mode and loads both park the dwell count at zero.
   assign clr_s     = enabled_s & (bus.load | ~scan_s);
   assign adv_en_s  = enabled_s & scan_s & ~bus.load;

   dwell_counter #(
      .DWELL (DWELL)
   ) u_dwell (
      .clk   (clk),
      .reset (reset),
      .clr   (clr_s),
      .en    (adv_en_s),
      .tc    (tc_s)
   );

   always_comb begin
      idx_d  = idx_q;
      wrap_d = 1'b0;
      y_d    = {N{INV}};
      if (load_s) begin
         idx_d = bus.sel;
      end else if (adv_en_s && tc_s) begin
         idx_d  = idx_q + SEL_W'(1);
         wrap_d = (idx_q == {SEL_W{1'b1}});
      end else begin
         idx_d = idx_q;
      end
      if (enabled_s) begin
         y_d = N'(onehot32(5'(idx_d))) ^ {N{INV}};
      end else begin
         y_d = {N{INV}};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         idx_q  <= {SEL_W{1'b0}};
         wrap_q <= 1'b0;
         y_q    <= {N{INV}};
      end else begin
         idx_q  <= idx_d;
         wrap_q <= wrap_d;
         y_q    <= y_d;
      end
   end

   assign bus.y    = y_q;
   assign bus.idx  = idx_q;
   assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_scan_decoder.sv
// Scoreboard bench: drivers push hand-computed expectations, one monitor pops
// and compares them shortly after each rising edge.
module tb_scan_decoder;
   logic clk = 1'b0;
   logic rst_ab;
   logic rst_c;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   scan_decoder_if #(.SEL_W(2)) if_a ();
   scan_decoder_if #(.SEL_W(2)) if_b ();
   scan_decoder_if #(.SEL_W(1)) if_c ();

   scan_decoder #(.SEL_W(2), .DWELL(3), .ACTIVE_LOW(0)) u_dut_a (
      .clk (clk), .reset (rst_ab), .bus (if_a.slave));
   scan_decoder #(.SEL_W(2), .DWELL(3), .ACTIVE_LOW(1)) u_dut_b (
      .clk (clk), .reset (rst_ab), .bus (if_b.slave));
   scan_decoder #(.SEL_W(1), .DWELL(1), .ACTIVE_LOW(0)) u_dut_c (
      .clk (clk), .reset (rst_c), .bus (if_c.slave));

   logic [6:0] qa[$];
   logic [6:0] qb[$];
   logic [3:0] qc[$];
   int         va = 0, vb = 0, vc = 0;

   task automatic drive_ab(input logic r, input logic en_n, input logic mode,
                           input logic load, input logic [1:0] sel,
                           input logic [3:0] ey, input logic [1:0] ei, input logic ew);
      @(negedge clk);
      rst_ab    = r;
      if_a.en_n = en_n; if_a.mode = mode; if_a.load = load; if_a.sel = sel;
      if_b.en_n = en_n; if_b.mode = mode; if_b.load = load; if_b.sel = sel;
      qa.push_back({ey, ei, ew});
      qb.push_back({~ey, ei, ew});
   endtask

   task automatic drive_c(input logic r, input logic en_n, input logic mode,
                          input logic load, input logic sel,
                          input logic [1:0] ey, input logic ei, input logic ew);
      @(negedge clk);
      rst_c     = r;
      if_c.en_n = en_n; if_c.mode = mode; if_c.load = load; if_c.sel = sel;
      qc.push_back({ey, ei, ew});
   endtask

   initial begin
      logic [6:0] ea, eb;
      logic [3:0] ec;
      forever begin
         @(posedge clk);
         #3;
         if (qa.size() > 0) begin
            ea = qa.pop_front();
            va++;
            n_checks++;
            if ({if_a.y, if_a.idx, if_a.wrap} !== ea) begin
               n_fail++;
               $display("FAIL dut_a vec %0d: got y=%b idx=%0d wrap=%b, expected y=%b idx=%0d wrap=%b",
                        va, if_a.y, if_a.idx, if_a.wrap, ea[6:3], ea[2:1], ea[0]);
            end
         end
         if (qb.size() > 0) begin
            eb = qb.pop_front();
            vb++;
            n_checks++;
            if ({if_b.y, if_b.idx, if_b.wrap} !== eb) begin
               n_fail++;
               $display("FAIL dut_b_active_low vec %0d: got y=%b idx=%0d wrap=%b, expected y=%b idx=%0d wrap=%b",
                        vb, if_b.y, if_b.idx, if_b.wrap, eb[6:3], eb[2:1], eb[0]);
            end
         end
         if (qc.size() > 0) begin
            ec = qc.pop_front();
            vc++;
            n_checks++;
            if ({if_c.y, if_c.idx, if_c.wrap} !== ec) begin
               n_fail++;
               $display("FAIL dut_c_dwell1 vec %0d: got y=%b idx=%0d wrap=%b, expected y=%b idx=%0d wrap=%b",
                        vc, if_c.y, if_c.idx, if_c.wrap, ec[3:2], ec[1], ec[0]);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_ab = 1'b1; rst_c = 1'b1;
      if_a.en_n = 1'b1; if_a.mode = 1'b0; if_a.load = 1'b0; if_a.sel = 2'd0;
      if_b.en_n = 1'b1; if_b.mode = 1'b0; if_b.load = 1'b0; if_b.sel = 2'd0;
      if_c.en_n = 1'b1; if_c.mode = 1'b0; if_c.load = 1'b0; if_c.sel = 1'b0;

      // Reset, including reset winning over a load strobe.
      drive_ab(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 2'd0, 1'b0);
      drive_ab(1'b1, 1'b1, 1'b1, 1'b1, 2'd3, 4'b0000, 2'd0, 1'b0);
      // Direct load, then hold while sel wiggles.
      drive_ab(1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0100, 2'd2, 1'b0);
      for (int i = 0; i < 5; i++)
         drive_ab(1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 4'b0100, 2'd2, 1'b0);
      drive_ab(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0001, 2'd0, 1'b0);
      // Twelve scan edges from idx 0, wrap on return to 0.
      for (int p = 0; p < 4; p++) begin
         for (int k = 0; k < 3; k++) begin
            logic [1:0] ei;
            logic [3:0] ey;
            ei = (k == 2) ? 2'(p + 1) : 2'(p);
            ey = 4'b0001 << ei;
            drive_ab(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, ey, ei, (p == 3 && k == 2) ? 1'b1 : 1'b0);
         end
      end
      // Reach idx 1 with cnt 1, then load 3 mid-dwell.
      drive_ab(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0001, 2'd0, 1'b0);
      drive_ab(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0001, 2'd0, 1'b0);
      drive_ab(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0010, 2'd1, 1'b0);
      drive_ab(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0010, 2'd1, 1'b0);
      drive_ab(1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 4'b1000, 2'd3, 1'b0);
      drive_ab(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 4'b1000, 2'd3, 1'b0);
      drive_ab(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 4'b1000, 2'd3, 1'b0);
      drive_ab(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0001, 2'd0, 1'b1);
      // Freeze at cnt 2 for four cycles, load ignored; resume advances at once.
      drive_ab(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0001, 2'd0, 1'b0);
      drive_ab(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0001, 2'd0, 1'b0);
      drive_ab(1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 4'b0000, 2'd0, 1'b0);
      for (int i = 0; i < 3; i++)
         drive_ab(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 4'b0000, 2'd0, 1'b0);
      drive_ab(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0010, 2'd1, 1'b0);
      // Scan to direct clears the dwell count; back to scan takes full dwell.
      drive_ab(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0010, 2'd1, 1'b0);
      drive_ab(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0010, 2'd1, 1'b0);
      drive_ab(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0010, 2'd1, 1'b0);
      drive_ab(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0010, 2'd1, 1'b0);
      drive_ab(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0100, 2'd2, 1'b0);
      drive_ab(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0100, 2'd2, 1'b0);
      drive_ab(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0100, 2'd2, 1'b0);
      drive_ab(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 4'b1000, 2'd3, 1'b0);
      drive_ab(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 4'b1000, 2'd3, 1'b0);
      drive_ab(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 4'b1000, 2'd3, 1'b0);
      // Load to 0 on the would-be wrap edge: no wrap pulse.
      drive_ab(1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 4'b0001, 2'd0, 1'b0);
      // Reset mid-dwell at idx 3; progress discarded.
      drive_ab(1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 4'b1000, 2'd3, 1'b0);
      drive_ab(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 4'b1000, 2'd3, 1'b0);
      drive_ab(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0000, 2'd0, 1'b0);
      drive_ab(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0001, 2'd0, 1'b0);
      drive_ab(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0001, 2'd0, 1'b0);
      drive_ab(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0010, 2'd1, 1'b0);

      // SEL_W=1, DWELL=1: toggle every enabled scan edge, wrap on each 1->0.
      drive_c(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
      drive_c(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0);
      drive_c(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1);
      drive_c(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0);
      drive_c(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1);
      drive_c(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
      drive_c(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0);
      drive_c(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0);
      drive_c(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0);
      drive_c(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0);
      drive_c(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1);

      repeat (3) @(posedge clk);
      #4;
      n_checks++;
      if (qa.size() + qb.size() + qc.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0",
                  qa.size() + qb.size() + qc.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/scan_decoder.md
SCAN_DECODER -- requirements
Module: scan_decoder

Interface
REQ-001 Parameter SEL_W, default 2, select width; output width N = 2**SEL_W; legal range 1..5.
REQ-002 Parameter DWELL, default 4, clock cycles each position is held in scan mode; legal range >= 1.
REQ-003 Parameter ACTIVE_LOW, default 0; when 1, every bit of y is inverted at the output.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 en_n  input  1  enable, active-low; 1 = block disabled.
REQ-007 mode  input  1  0 = direct (load-driven), 1 = auto-scan.
REQ-008 sel  input  SEL_W  index to load.
REQ-009 load  input  1  single-cycle strobe; captures sel into idx.
REQ-010 y  output  N  registered one-hot decode of idx.
REQ-011 idx  output  SEL_W  current registered index.
REQ-012 wrap  output  1  one-cycle pulse when scan advances from N-1 to 0.

Function
REQ-013 The block SHALL hold internal state idx (SEL_W bits) and dwell count cnt (0..DWELL-1).
REQ-014 After every non-reset edge, y SHALL equal onehot(idx) if en_n was sampled 0 at that edge, else all zeros; inverted when ACTIVE_LOW=1; latency load-to-y 1 cycle.
REQ-015 en_n=1: idx and cnt SHALL hold (freeze), load SHALL be ignored, wrap SHALL be 0.
REQ-016 Direct mode, en_n=0, load=1: idx SHALL take sel at the edge; cnt SHALL clear to 0.
REQ-017 Direct mode, load=0: idx SHALL hold; cnt SHALL stay 0.
REQ-018 Scan mode, en_n=0, load=0: cnt SHALL increment each edge; at cnt=DWELL-1 cnt SHALL clear and idx SHALL increment modulo N.
REQ-019 wrap SHALL be 1 for exactly the cycle following the edge at which idx goes N-1 -> 0 via scan advance; never on load or reset.
REQ-020 Scan mode with load=1 (en_n=0): load SHALL win; idx := sel, cnt := 0, no advance, no wrap.
REQ-021 DWELL=1: idx SHALL advance on every enabled scan edge.
REQ-022 Mode change scan->direct: idx SHALL hold, cnt SHALL clear; direct->scan: scan SHALL start from current idx with cnt=0, first advance after DWELL edges.
REQ-023 SEL_W=1: N=2, idx toggles 0/1 in scan, wrap on each 1->0.
REQ-024 Priority at any edge: reset > en_n=1 > load > scan advance.

Reset
REQ-025 reset=1 at an edge SHALL force idx=0, cnt=0, wrap=0, y=all zeros (all ones if ACTIVE_LOW=1), regardless of other inputs.
REQ-026 Reset asserted mid-scan or mid-dwell SHALL discard progress; first enabled edge after release SHALL give y=onehot(0) with cnt restarting at 0.

Structure
REQ-027 A shared header (scan_decoder_defs) SHALL hold mode encodings (MODE_DIRECT=0, MODE_SCAN=1) and the onehot width function.
REQ-028 The dwell counter SHALL be a sub-module dwell_counter (parameter DWELL; inputs clk, reset, clr, en; output tc).
REQ-029 Out-of-range parameters SHALL be rejected at elaboration.

Verification (SEL_W=2, DWELL=3, ACTIVE_LOW=0 unless stated)
REQ-030 Reset then en_n=0, mode=0, load=1 sel=2 -> next cycle idx=2, y=0100; hold load=0 for 5 cycles -> y stays 0100.
REQ-031 mode=1 from idx=0 for 12 cycles -> idx 0,1,2,3 each held 3 cycles; wrap=1 for one cycle when idx returns to 0.
REQ-032 Scan at idx=1, cnt=1, pulse load sel=3 -> idx=3, next advance to 0 exactly 3 edges later with wrap=1.
REQ-033 Scan running, en_n=1 for 4 cycles -> y=0000, idx/cnt frozen, wrap=0; en_n=0 -> resumes from frozen cnt.
REQ-034 reset=1 during scan at idx=3 -> y=0000, idx=0, wrap=0; ACTIVE_LOW=1 build -> y=1111 under reset and 1110 at idx=0 enabled.
REQ-035 DWELL=1, SEL_W=1 -> idx toggles every cycle, wrap every second cycle.
